// File: rtl/jellyvl_etherneco_ring_scheduler_pkg.sv
// Shared state encoding, field widths and helpers for the etherneco ring scheduler.
package jellyvl_etherneco_ring_scheduler_pkg;

  localparam int TYPE_WIDTH   = 8;
  localparam int LENGTH_WIDTH = 16;
  localparam int INDEX_WIDTH  = 3;
  localparam int STAT_WIDTH   = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] value);
    return (&value) ? value : value + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/jellyvl_etherneco_rr_arbiter.sv
// Round-robin selector: picks the first set request at or after ptr, wrapping to index 0.
module jellyvl_etherneco_rr_arbiter
  import jellyvl_etherneco_ring_scheduler_pkg::*;
#(
  parameter int REQ_NUM = 4
) (
  input  logic [REQ_NUM-1:0]     req,
  input  logic [INDEX_WIDTH-1:0] ptr,
  output logic [REQ_NUM-1:0]     grant,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   found
);

  // First pass searches [ptr, REQ_NUM), second pass covers the wrap-around part.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int j = 0; j < REQ_NUM; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        index    = INDEX_WIDTH'(j);
      end
    end
    for (int j = 0; j < REQ_NUM; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        index    = INDEX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/jellyvl_etherneco_ring_scheduler.sv
// Master-side slot sequencer for the etherneco ring: periodic slot, round-robin grant, command, wait for return.
// Define JELLYVL_ETHERNECO_RING_SCHEDULER_STATS_EN to add overrun/timeout/error statistics counters.
module jellyvl_etherneco_ring_scheduler
  import jellyvl_etherneco_ring_scheduler_pkg::*;
#(
  parameter int REQ_NUM       = 4,
  parameter int PERIOD_WIDTH  = 32,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [PERIOD_WIDTH-1:0]         param_period,
  input  logic [TIMEOUT_WIDTH-1:0]        param_timeout,
  input  logic [REQ_NUM-1:0]              s_req_valid,
  input  logic [REQ_NUM*TYPE_WIDTH-1:0]   s_req_type,
  input  logic [REQ_NUM*LENGTH_WIDTH-1:0] s_req_length,
  output logic [REQ_NUM-1:0]              s_req_ready,
  output logic                            m_cmd_valid,
  input  logic                            m_cmd_ready,
  output logic [TYPE_WIDTH-1:0]           m_cmd_type,
  output logic [LENGTH_WIDTH-1:0]         m_cmd_length,
  input  logic                            rx_end,
  input  logic                            rx_error,
  input  logic [TYPE_WIDTH-1:0]           rx_type,
  output logic                            done_valid,
  output logic [INDEX_WIDTH-1:0]          done_index,
  output logic                            done_error,
  output logic                            done_timeout,
  output logic                            busy
`ifdef JELLYVL_ETHERNECO_RING_SCHEDULER_STATS_EN
  ,
  input  logic                            stat_clear,
  output logic [STAT_WIDTH-1:0]           stat_overrun,
  output logic [STAT_WIDTH-1:0]           stat_timeout,
  output logic [STAT_WIDTH-1:0]           stat_error
`endif
);

  state_t                   state;
  logic [PERIOD_WIDTH-1:0]  period_cnt;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [INDEX_WIDTH-1:0]   rr_ptr;
  logic [INDEX_WIDTH-1:0]   cur_index;
  logic                     tick;

  logic [REQ_NUM-1:0]       arb_grant;
  logic [INDEX_WIDTH-1:0]   arb_index;
  logic                     arb_found;
  logic [INDEX_WIDTH-1:0]   arb_next_ptr;
  logic [TYPE_WIDTH-1:0]    arb_type;
  logic [LENGTH_WIDTH-1:0]  arb_length;

  logic                     rx_hit;
  logic                     tmo_hit;
  logic                     rx_bad;

  // The >= guards against param_period being lowered below the running count.
  assign tick = enable && (period_cnt >= param_period);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (!enable || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_WIDTH'(1);
    end
  end

  jellyvl_etherneco_rr_arbiter #(
    .REQ_NUM (REQ_NUM)
  ) u_rr_arbiter (
    .req   (s_req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .index (arb_index),
    .found (arb_found)
  );

  assign arb_next_ptr = (arb_index == INDEX_WIDTH'(REQ_NUM - 1)) ? '0 : arb_index + INDEX_WIDTH'(1);

  always_comb begin
    arb_type   = '0;
    arb_length = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (arb_grant[i]) begin
        arb_type   = s_req_type[i*TYPE_WIDTH +: TYPE_WIDTH];
        arb_length = s_req_length[i*LENGTH_WIDTH +: LENGTH_WIDTH];
      end
    end
  end

  // A return in the final counting cycle still beats the timeout.
  assign rx_hit  = (state == WAIT) && rx_end;
  assign tmo_hit = (state == WAIT) && !rx_end && (tmo_cnt <= TIMEOUT_WIDTH'(1));
  assign rx_bad  = rx_error || (rx_type != m_cmd_type);

  // The grant is decided on the tick and registered, so the ready pulse and latched fields appear during ARB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_index    <= '0;
      tmo_cnt      <= '0;
      s_req_ready  <= '0;
      m_cmd_valid  <= 1'b0;
      m_cmd_type   <= '0;
      m_cmd_length <= '0;
      done_valid   <= 1'b0;
      done_index   <= '0;
      done_error   <= 1'b0;
      done_timeout <= 1'b0;
    end else begin
      s_req_ready  <= '0;
      done_valid   <= 1'b0;
      done_index   <= '0;
      done_error   <= 1'b0;
      done_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && arb_found) begin
            s_req_ready  <= arb_grant;
            cur_index    <= arb_index;
            m_cmd_type   <= arb_type;
            m_cmd_length <= arb_length;
            rr_ptr       <= arb_next_ptr;
            state        <= ARB;
          end
        end
        ARB: begin
          m_cmd_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (m_cmd_ready) begin
            m_cmd_valid <= 1'b0;
            tmo_cnt     <= param_timeout;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (rx_hit) begin
            done_valid <= 1'b1;
            done_index <= cur_index;
            done_error <= rx_bad;
            state      <= DONE;
          end else if (tmo_hit) begin
            done_valid   <= 1'b1;
            done_index   <= cur_index;
            done_timeout <= 1'b1;
            state        <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - TIMEOUT_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef JELLYVL_ETHERNECO_RING_SCHEDULER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_overrun <= '0;
      stat_timeout <= '0;
      stat_error   <= '0;
    end else if (stat_clear) begin
      stat_overrun <= '0;
      stat_timeout <= '0;
      stat_error   <= '0;
    end else begin
      if (tick && (state != IDLE)) begin
        stat_overrun <= stat_inc(stat_overrun);
      end
      if (tmo_hit) begin
        stat_timeout <= stat_inc(stat_timeout);
      end
      if (rx_hit && rx_bad) begin
        stat_error <= stat_inc(stat_error);
      end
    end
  end
`endif

endmodule
